// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer that shares one ALU among NREQ requesters: latch operands,
// execute for one cycle, then return result/zero over a per-requester valid/ready handshake.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   a_bus,
  input  logic [NREQ*32-1:0]   b_bus,
  input  logic [NREQ*3-1:0]    alucont_bus,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          result,
  output logic                 zero,
  output logic                 busy,
  output logic [CNTW-1:0]      ops_done
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_reg;
  logic [OW-1:0]   owner_reg;
  logic [OW-1:0]   last_reg;
  logic [31:0]     opa_reg;
  logic [31:0]     opb_reg;
  logic [2:0]      opc_reg;
  logic [31:0]     res_q;
  logic            zero_q;
  logic [CNTW-1:0] ops_done_reg;

  logic [OW-1:0]   win_next;
  logic            any_req;
  logic [OW:0]     scan_sum;
  logic [OW-1:0]   scan_idx;
  logic [31:0]     alu_result;
  logic            alu_zero;

  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    win_next = '0;
    scan_sum = '0;
    scan_idx = '0;
    any_req  = |req;
    for (int k = NREQ; k >= 1; k--) begin
      scan_sum = {1'b0, last_reg} + (OW+1)'(k);
      if (scan_sum >= (OW+1)'(NREQ))
        scan_sum = scan_sum - (OW+1)'(NREQ);
      scan_idx = scan_sum[OW-1:0];
      if (req[scan_idx])
        win_next = scan_idx;
    end
  end

  alu u_alu (
    .a       (opa_reg),
    .b       (opb_reg),
    .alucont (opc_reg),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      last_reg     <= OW'(NREQ-1);
      opa_reg      <= '0;
      opb_reg      <= '0;
      opc_reg      <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      ops_done_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            opa_reg   <= a_bus[win_next*32 +: 32];
            opb_reg   <= b_bus[win_next*32 +: 32];
            opc_reg   <= alucont_bus[win_next*3 +: 3];
            owner_reg <= win_next;
            last_reg  <= win_next;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          res_q     <= alu_result;
          zero_q    <= alu_zero;
          state_reg <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_reg]) begin
            ops_done_reg <= ops_done_reg + 1'b1;
            if (any_req) begin
              opa_reg   <= a_bus[win_next*32 +: 32];
              opb_reg   <= b_bus[win_next*32 +: 32];
              opc_reg   <= alucont_bus[win_next*3 +: 3];
              owner_reg <= win_next;
              last_reg  <= win_next;
              state_reg <= EXEC;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake outputs depend only on registered state and owner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
    assign gnt[gi]       = (state_reg == EXEC) && (owner_reg == OW'(gi));
    assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == OW'(gi));
  end

  assign result   = res_q;
  assign zero     = zero_q;
  assign busy     = (state_reg != IDLE);
  assign ops_done = ops_done_reg;
endmodule

// 32-bit ALU: AND / OR / add / set-less-than, with bit 2 selecting invert-B-plus-one.
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alucont,
  output logic [31:0] result,
  output logic        zero
);
  logic [31:0] b_sel;
  logic [31:0] sum;

  assign b_sel = alucont[2] ? ~b : b;
  assign sum   = a + b_sel + {31'b0, alucont[2]};

  always_comb begin
    result = '0;
    case (alucont[1:0])
      2'b00:   result = a & b_sel;
      2'b01:   result = a | b_sel;
      2'b10:   result = sum;
      default: result = {31'b0, sum[31]};
    endcase
  end

  assign zero = (result == 32'b0);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: single op, fairness, back-pressure,
// operand isolation, reset mid-operation and counter wrap (CNTW=4).
module tb_alu_share_arbiter;
  localparam int NREQ = 4;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] a_bus;
  logic [NREQ*32-1:0] b_bus;
  logic [NREQ*3-1:0] alucont_bus;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [31:0]       result;
  logic              zero;
  logic              busy;
  logic [CNTW-1:0]   ops_done;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .a_bus       (a_bus),
    .b_bus       (b_bus),
    .alucont_bus (alucont_bus),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req = '0;
    rsp_ready = '0;
    a_bus = '0;
    b_bus = '0;
    alucont_bus = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ops_done", 32'(ops_done), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    reset = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    $display("txn reset: checks done");

    // Single requester: 7 - 5 = 2
    a_bus[63:32] = 32'd7;
    b_bus[63:32] = 32'd5;
    alucont_bus[5:3] = 3'b110;
    req = 4'b0010;
    rsp_ready = 4'b0010;
    tick();
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_no_valid", 32'(rsp_valid), 32'h0);
    chk("single_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    chk("single_gnt_drop", 32'(gnt), 32'h0);
    chk("single_valid", 32'(rsp_valid), 32'h2);
    chk("single_result", result, 32'd2);
    chk("single_zero", 32'(zero), 32'h0);
    chk("single_cnt0", 32'(ops_done), 32'h0);
    tick();
    chk("single_cnt1", 32'(ops_done), 32'h1);
    chk("single_idle_valid", 32'(rsp_valid), 32'h0);
    chk("single_idle_busy", 32'(busy), 32'h0);
    chk("single_hold_result", result, 32'd2);
    $display("txn single: result=%0d ops_done=%0d", result, ops_done);

    // Fairness: requester i computes (i+1) + 10
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_bus[32*i +: 32] = 32'(i + 1);
      b_bus[32*i +: 32] = 32'd10;
      alucont_bus[3*i +: 3] = 3'b010;
    end
    req = 4'b1111;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fair_gnt", 32'(gnt), 32'(1 << (k % 4)));
      tick();
      chk("fair_valid", 32'(rsp_valid), 32'(1 << (k % 4)));
      chk("fair_result", result, 32'(11 + (k % 4)));
      $display("txn fair: op=%0d owner=%0d result=%0d", k, k % 4, result);
    end
    req = '0;
    tick();
    chk("fair_ops_done", 32'(ops_done), 32'd8);
    chk("fair_idle", 32'(busy), 32'h0);

    // Back-pressure: 9 - 9 = 0, zero=1; rsp_ready[0] must be ignored
    do_reset();
    a_bus[95:64] = 32'd9;
    b_bus[95:64] = 32'd9;
    alucont_bus[8:6] = 3'b110;
    req = 4'b0100;
    rsp_ready = 4'b0001;
    tick();
    chk("bp_gnt", 32'(gnt), 32'h4);
    req = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'h4);
      chk("bp_result", result, 32'h0);
      chk("bp_zero", 32'(zero), 32'h1);
      chk("bp_cnt", 32'(ops_done), 32'h0);
    end
    rsp_ready = 4'b0100;
    tick();
    chk("bp_release_valid", 32'(rsp_valid), 32'h0);
    chk("bp_release_cnt", 32'(ops_done), 32'h1);
    $display("txn backpressure: released ops_done=%0d", ops_done);

    // Operand isolation: bus change after grant must not reach the ALU
    do_reset();
    a_bus[31:0] = 32'hFFFF0000;
    b_bus[31:0] = 32'h00FF00FF;
    alucont_bus[2:0] = 3'b000;
    req = 4'b0001;
    rsp_ready = 4'b0001;
    tick();
    chk("iso_gnt", 32'(gnt), 32'h1);
    a_bus[31:0] = 32'h0;
    req = '0;
    tick();
    chk("iso_result", result, 32'h00FF0000);
    chk("iso_zero", 32'(zero), 32'h0);
    tick();
    chk("iso_cnt", 32'(ops_done), 32'h1);
    $display("txn isolation: result=%0h", result);

    // Reset during RESP abandons the operation
    req = 4'b0001;
    rsp_ready = 4'b0000;
    tick();
    req = '0;
    tick();
    chk("rmid_valid_before", 32'(rsp_valid), 32'h1);
    reset = 1'b0;
    tick();
    chk("rmid_valid", 32'(rsp_valid), 32'h0);
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_cnt", 32'(ops_done), 32'h0);
    reset = 1'b1;
    req = 4'b1001;
    rsp_ready = 4'b1001;
    tick();
    chk("rmid_first_gnt", 32'(gnt), 32'h1);
    req = 4'b1000;
    tick();
    tick();
    chk("rmid_second_gnt", 32'(gnt), 32'h8);
    req = '0;
    tick();
    tick();
    chk("rmid_cnt_after", 32'(ops_done), 32'h2);
    $display("txn reset_mid: ops_done=%0d", ops_done);

    // Counter wrap: 17 operations with a 4-bit counter
    do_reset();
    req = 4'b1111;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk("wrap_gnt", 32'(gnt), 32'(1 << (k % 4)));
      chk("wrap_cnt", 32'(ops_done), 32'(k % 16));
      tick();
      chk("wrap_valid", 32'(rsp_valid), 32'(1 << (k % 4)));
      $display("txn wrap: op=%0d ops_done=%0d", k, ops_done);
    end
    req = '0;
    tick();
    chk("wrap_final_cnt", 32'(ops_done), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
